// File: rtl/alu_pkg.sv
// ============================================================================
// Module   : alu_pkg
// Purpose  : Opcode/func encodings, FSM states and field helpers for the
//            ALU write-back stage.
// Revision : 1.0
// ============================================================================
`default_nettype none

package alu_pkg;

    // Primary opcodes, instruction bits [31:26]
    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] OP_ADDI    = 6'b001000;
    localparam logic [5:0] OP_ADDIU   = 6'b001001;
    localparam logic [5:0] OP_SLTI    = 6'b001010;
    localparam logic [5:0] OP_SLTIU   = 6'b001011;
    localparam logic [5:0] OP_ANDI    = 6'b001100;
    localparam logic [5:0] OP_ORI     = 6'b001101;
    localparam logic [5:0] OP_XORI    = 6'b001110;
    localparam logic [5:0] OP_LW      = 6'b100011;
    localparam logic [5:0] OP_SW      = 6'b101011;

    // SPECIAL func codes, instruction bits [5:0]
    localparam logic [5:0] FN_SLL   = 6'b000000;
    localparam logic [5:0] FN_SRL   = 6'b000010;
    localparam logic [5:0] FN_SRA   = 6'b000011;
    localparam logic [5:0] FN_SLLV  = 6'b000100;
    localparam logic [5:0] FN_SRLV  = 6'b000110;
    localparam logic [5:0] FN_SRAV  = 6'b000111;
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_XOR   = 6'b100110;
    localparam logic [5:0] FN_NOR   = 6'b100111;
    localparam logic [5:0] FN_SLT   = 6'b101010;
    localparam logic [5:0] FN_SLTU  = 6'b101011;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE     = 2'd0;
    localparam state_t ST_COMMIT   = 2'd1;
    localparam state_t ST_MEM_REQ  = 2'd2;
    localparam state_t ST_MEM_WAIT = 2'd3;

    function automatic logic [5:0] f_op(input logic [31:0] instr);
        return instr[31:26];
    endfunction

    function automatic logic [5:0] f_func(input logic [31:0] instr);
        return instr[5:0];
    endfunction

    function automatic logic [4:0] f_rs(input logic [31:0] instr);
        return instr[25:21];
    endfunction

    function automatic logic [4:0] f_rt(input logic [31:0] instr);
        return instr[20:16];
    endfunction

    function automatic logic [4:0] f_rd(input logic [31:0] instr);
        return instr[15:11];
    endfunction

    function automatic logic [15:0] f_imm16(input logic [31:0] instr);
        return instr[15:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/gpr_file.sv
// ============================================================================
// Module   : gpr_file
// Purpose  : 32x32 register file, asynchronous reads, one synchronous write,
//            register 0 reads as zero and ignores writes.
// Revision : 1.0
// ============================================================================
`default_nettype none

module gpr_file #(
    parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_we,
    input  logic [4:0]  i_waddr,
    input  logic [31:0] i_wdata,
    input  logic [4:0]  i_raddr1,
    input  logic [4:0]  i_raddr2,
    input  logic [4:0]  i_raddr3,
    output logic [31:0] o_rdata1,
    output logic [31:0] o_rdata2,
    output logic [31:0] o_rdata3
);

    logic [31:0] r_regs [32];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= RESET_VAL;
            end
        end else if (i_we && (i_waddr != 5'd0)) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    // Third port supplies store data to the commit logic.
    assign o_rdata1 = (i_raddr1 == 5'd0) ? 32'h0 : r_regs[i_raddr1];
    assign o_rdata2 = (i_raddr2 == 5'd0) ? 32'h0 : r_regs[i_raddr2];
    assign o_rdata3 = (i_raddr3 == 5'd0) ? 32'h0 : r_regs[i_raddr3];

endmodule

`default_nettype wire

// File: rtl/alu_writeback.sv
// ============================================================================
// Module   : alu_writeback
// Purpose  : Commit stage behind the ALU: GPR/HI/LO write-back, branch
//            resolution and a single-outstanding load/store handshake.
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu_writeback
    import alu_pkg::*;
#(
    parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] i_datain,
    input  logic [31:0] pc,
    input  logic [31:0] c,
    input  logic [2:0]  zon,
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    input  logic [4:0]  rd_addr1,
    input  logic [4:0]  rd_addr2,
    output logic [31:0] rd_data1,
    output logic [31:0] rd_data2,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        br_taken,
    output logic [31:0] br_target,
    output logic        ovf_exc,
    output logic        illegal,
    output logic [31:0] hi_q,
    output logic [31:0] lo_q
);

    state_t      r_state;
    logic [31:0] r_instr, r_pc, r_c, r_hi_in, r_lo_in;
    logic [2:0]  r_zon;
    logic [31:0] r_hi, r_lo;
    logic [31:0] r_mem_addr, r_mem_wdata;

    logic [5:0]  w_op, w_fn;
    logic        w_special, w_r_alu, w_i_alu, w_muldiv, w_mfhi, w_mflo;
    logic        w_beq, w_bne, w_lw, w_sw, w_legal, w_ovf_chk, w_commit;
    logic        w_gpr_we;
    logic [4:0]  w_gpr_waddr;
    logic [31:0] w_gpr_wdata, w_store_data, w_br_off;

    assign w_op      = f_op(r_instr);
    assign w_fn      = f_func(r_instr);
    assign w_special = (w_op == OP_SPECIAL);
    assign w_commit  = (r_state == ST_COMMIT);

    always_comb begin
        w_r_alu  = 1'b0;
        w_muldiv = 1'b0;
        w_mfhi   = 1'b0;
        w_mflo   = 1'b0;
        if (w_special) begin
            case (w_fn)
                FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_NOR, FN_OR,
                FN_XOR, FN_SLT, FN_SLTU, FN_SLL, FN_SLLV, FN_SRL, FN_SRLV,
                FN_SRA, FN_SRAV:                       w_r_alu  = 1'b1;
                FN_MULT, FN_MULTU, FN_DIV, FN_DIVU:    w_muldiv = 1'b1;
                FN_MFHI:                               w_mfhi   = 1'b1;
                FN_MFLO:                               w_mflo   = 1'b1;
                default: ;
            endcase
        end
    end

    assign w_i_alu = (w_op == OP_ADDI) || (w_op == OP_ADDIU) || (w_op == OP_ANDI) ||
                     (w_op == OP_ORI)  || (w_op == OP_XORI)  || (w_op == OP_SLTI) ||
                     (w_op == OP_SLTIU);
    assign w_beq   = (w_op == OP_BEQ);
    assign w_bne   = (w_op == OP_BNE);
    assign w_lw    = (w_op == OP_LW);
    assign w_sw    = (w_op == OP_SW);
    assign w_legal = w_r_alu || w_muldiv || w_mfhi || w_mflo || w_i_alu ||
                     w_beq || w_bne || w_lw || w_sw;

    // Only the trapping adds/subs honour the overflow flag.
    assign w_ovf_chk = (w_special && ((w_fn == FN_ADD) || (w_fn == FN_SUB))) ||
                       (w_op == OP_ADDI);

    always_comb begin
        w_gpr_we    = 1'b0;
        w_gpr_waddr = 5'd0;
        w_gpr_wdata = 32'h0;
        if (w_commit) begin
            if ((w_r_alu || w_i_alu) && !(w_ovf_chk && r_zon[1])) begin
                w_gpr_we    = 1'b1;
                w_gpr_waddr = w_r_alu ? f_rd(r_instr) : f_rt(r_instr);
                w_gpr_wdata = r_c;
            end else if (w_mfhi || w_mflo) begin
                w_gpr_we    = 1'b1;
                w_gpr_waddr = f_rd(r_instr);
                w_gpr_wdata = w_mfhi ? r_hi : r_lo;
            end
        end else if ((r_state == ST_MEM_WAIT) && mem_rvalid) begin
            w_gpr_we    = 1'b1;
            w_gpr_waddr = f_rt(r_instr);
            w_gpr_wdata = mem_rdata;
        end
    end

    gpr_file #(
        .RESET_VAL (RESET_VAL)
    ) u_gpr (
        .clk      (clk),
        .rst      (rst),
        .i_we     (w_gpr_we),
        .i_waddr  (w_gpr_waddr),
        .i_wdata  (w_gpr_wdata),
        .i_raddr1 (rd_addr1),
        .i_raddr2 (rd_addr2),
        .i_raddr3 (f_rt(r_instr)),
        .o_rdata1 (rd_data1),
        .o_rdata2 (rd_data2),
        .o_rdata3 (w_store_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_instr     <= 32'h0;
            r_pc        <= 32'h0;
            r_c         <= 32'h0;
            r_zon       <= 3'b000;
            r_hi_in     <= 32'h0;
            r_lo_in     <= 32'h0;
            r_hi        <= RESET_VAL;
            r_lo        <= RESET_VAL;
            r_mem_addr  <= 32'h0;
            r_mem_wdata <= 32'h0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_instr <= i_datain;
                        r_pc    <= pc;
                        r_c     <= c;
                        r_zon   <= zon;
                        r_hi_in <= hi;
                        r_lo_in <= lo;
                        r_state <= ST_COMMIT;
                    end
                end
                ST_COMMIT: begin
                    if (w_muldiv) begin
                        r_hi <= r_hi_in;
                        r_lo <= r_lo_in;
                    end
                    if (w_lw || w_sw) begin
                        r_mem_addr  <= r_c;
                        r_mem_wdata <= w_sw ? w_store_data : 32'h0;
                        r_state     <= ST_MEM_REQ;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_MEM_REQ: begin
                    if (mem_ready) begin
                        r_state <= w_sw ? ST_IDLE : ST_MEM_WAIT;
                    end
                end
                ST_MEM_WAIT: begin
                    if (mem_rvalid) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign w_br_off  = {{14{r_instr[15]}}, f_imm16(r_instr), 2'b00};

    assign in_ready  = (r_state == ST_IDLE) && !rst;
    assign br_taken  = w_commit && ((w_beq && r_zon[2]) || (w_bne && !r_zon[2]));
    assign br_target = (w_commit && (w_beq || w_bne)) ? (r_pc + 32'd4 + w_br_off) : 32'h0;
    assign ovf_exc   = w_commit && w_ovf_chk && r_zon[1];
    assign illegal   = w_commit && !w_legal;
    assign mem_valid = (r_state == ST_MEM_REQ);
    assign mem_we    = (r_state == ST_MEM_REQ) && w_sw;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign hi_q      = r_hi;
    assign lo_q      = r_lo;

endmodule

`default_nettype wire
